// File: rtl/pipe_pkg.sv
// Shared types and constants for the flow-controlled pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_e;

  localparam logic [31:0] BUBBLE_OPCODE = 32'h0000_0000;
  localparam int          PERF_CNT_W    = 32;

endpackage

// File: rtl/pipe_stage_skid_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear, used for stage perf counters.
module sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Hold at all-ones so a long-running counter never wraps back to a small value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer, global advance gating and flush.
// Perf counters are built only when PIPE_STAGE_PERF_EN is defined; otherwise they read 0.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 128,
  parameter int                DONE_N = 2,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_OPCODE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DONE_N-1:0]     done,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            occupancy,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] bubble_cycles
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic adv;
  logic push;
  logic pop;

  assign adv       = &done;
  assign in_ready  = adv & ~stall & (state_q != PS_TWO);
  assign out_valid = (state_q != PS_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & adv;
  assign out_data  = main_q;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      PS_ONE:  occupancy = 2'd1;
      PS_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Empty slots always hold BUBBLE so out_data needs no extra mux on out_valid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (adv) begin
      if (flush) begin
        state_d = PS_EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end else begin
        case (state_q)
          PS_EMPTY: begin
            if (push) begin
              state_d = PS_ONE;
              main_d  = in_data;
            end
          end
          PS_ONE: begin
            if (push && pop) begin
              main_d = in_data;
            end else if (push) begin
              state_d = PS_TWO;
              skid_d  = in_data;
            end else if (pop) begin
              state_d = PS_EMPTY;
              main_d  = BUBBLE;
            end
          end
          PS_TWO: begin
            if (pop) begin
              state_d = PS_ONE;
              main_d  = skid_q;
              skid_d  = BUBBLE;
            end
          end
          default: begin
            state_d = PS_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PS_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stallInc;
  logic bubbleInc;

  assign stallInc  = adv & in_valid & ~in_ready;
  assign bubbleInc = adv & out_ready & ~out_valid;

  sat_cnt #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallInc),
    .count (stall_cycles)
  );

  sat_cnt #(.WIDTH(PERF_CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubbleInc),
    .count (bubble_cycles)
  );
`else
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios followed by randomized traffic.
module tb_pipe_stage_skid;

  localparam int          DW     = 16;
  localparam logic [15:0] BUBBLE = 16'hB0B0;

  logic          clk;
  logic          rst;
  logic [1:0]    done;
  logic          flush;
  logic          stall;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [1:0]    occupancy;
  logic [31:0]   stallCycles;
  logic [31:0]   bubbleCycles;

  pipe_stage_skid #(.DATA_W(DW), .DONE_N(2), .BUBBLE(BUBBLE)) dut (
    .clk           (clk),
    .rst           (rst),
    .done          (done),
    .flush         (flush),
    .stall         (stall),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .in_data       (inData),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .out_data      (outData),
    .occupancy     (occupancy),
    .stall_cycles  (stallCycles),
    .bubble_cycles (bubbleCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] expQ[$];
  logic [31:0]   expStall  = 0;
  logic [31:0]   expBubble = 0;
  logic          monitorOn = 1'b0;
  logic          acceptNow = 1'b0;
  logic          pushNow   = 1'b0;
  logic          lastAccepted = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outputs come from an abstract FIFO of capacity two plus plain counters.
  always @(negedge clk) begin
    logic expReady;
    logic adv;
    adv       = &done;
    expReady  = adv & ~stall & (expQ.size() < 2);
    acceptNow = 1'b0;
    pushNow   = 1'b0;
    if (monitorOn) begin
      checkOutput("in_ready", 64'(inReady), 64'(expReady));
      checkOutput("out_valid", 64'(outValid), 64'(expQ.size() != 0));
      checkOutput("out_data", 64'(outData), 64'((expQ.size() != 0) ? expQ[0] : BUBBLE));
      checkOutput("occupancy", 64'(occupancy), 64'(expQ.size()));
`ifdef PIPE_STAGE_PERF_EN
      checkOutput("stall_cycles", 64'(stallCycles), 64'(expStall));
      checkOutput("bubble_cycles", 64'(bubbleCycles), 64'(expBubble));
`else
      checkOutput("stall_cycles", 64'(stallCycles), 64'(0));
      checkOutput("bubble_cycles", 64'(bubbleCycles), 64'(0));
`endif
      if (rst) begin
        expQ.delete();
        expStall  = 0;
        expBubble = 0;
      end else if (adv) begin
        if (inValid && !expReady && expStall != 32'hFFFF_FFFF) expStall++;
        if (outReady && expQ.size() == 0 && expBubble != 32'hFFFF_FFFF) expBubble++;
        acceptNow = inValid & expReady;
        if (flush) begin
          expQ.delete();
        end else begin
          if (outReady && expQ.size() != 0) void'(expQ.pop_front());
          pushNow = acceptNow;
        end
      end
    end
  end

  // Accepted payloads enter the scoreboard just after the monitor retires the head.
  always @(negedge clk) begin
    #1;
    if (pushNow) expQ.push_back(inData);
    lastAccepted = acceptNow;
  end

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [1:0] dn,
                               input logic fl, input logic st, input logic ordy, input logic rs);
    @(posedge clk);
    #1;
    inValid  = v;
    inData   = d;
    done     = dn;
    flush    = fl;
    stall    = st;
    outReady = ordy;
    rst      = rs;
    monitorOn = 1'b1;
  endtask

  task automatic randomCycle();
    logic          v;
    logic [DW-1:0] d;
    if (inValid && !lastAccepted && !rst) begin
      v = 1'b1;
      d = inData;
    end else begin
      v = ($urandom_range(0, 99) < 60);
      d = DW'($urandom);
    end
    applyStimulus(v, d,
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11,
                  ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 299) == 0));
  endtask

  initial begin
    rst = 1'b1; done = 2'b11; flush = 1'b0; stall = 1'b0;
    inValid = 1'b1; inData = 16'h00A5; outReady = 1'b0;

    applyStimulus(1'b1, 16'h00A5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h00A5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);

    // Stall with an empty stage: both perf counters tick every cycle.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0077, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef PIPE_STAGE_PERF_EN
    checkOutput("perf_stall_5", 64'(stallCycles), 64'(5));
    checkOutput("perf_bubble_5", 64'(bubbleCycles), 64'(5));
`else
    checkOutput("perf_stall_off", 64'(stallCycles), 64'(0));
    checkOutput("perf_bubble_off", 64'(bubbleCycles), 64'(0));
`endif

    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DW'(i), 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 16'h0010, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0011, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0012, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0012, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 16'h0020, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0021, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0021, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h0030, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0031, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0033, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while two entries are held must drop both.
    applyStimulus(1'b1, 16'h0040, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0041, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0042, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 800; i++) randomCycle();

    applyStimulus(1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
